satatrn_rxsplit: RTL and testbench

- Receive-side counterpart of the transport TX arbiter.
- Accepts the single FIS stream delivered by the link layer, one 32-bit word per beat, and classifies each FIS by the type byte of its first word.
- Data FIS (type 8'h46): the header word is stripped and the payload is forwarded on the data stream.
- Every other FIS, header included, is forwarded whole on the register stream.
- Runs entirely in the PHY/link clock domain. CDC toward the bus clock is the consumer's job.

---
 rtl/satatrn_rxsplit.sv | 165 ++++++++++++++++
 tb/tb_satatrn_rxsplit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/satatrn_rxsplit.sv
// satatrn_rxsplit: receive-side transport splitter.
// Classifies each incoming FIS by the type byte of its first word. A data FIS
// (8'h46) loses its header and its payload goes to the data stream. Any other
// FIS is passed whole to the register stream. Each output is a single
// registered stage with standard valid/ready handshaking.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a header word
//   DATA   | forwarding data-FIS payload words, counting them
//   REG    | forwarding the remaining words of a register FIS
//   DROP   | payload exceeded 2^LGMAXDATA words; discard until last
module satatrn_rxsplit #(
   parameter int LGMAXDATA    = 11,
   parameter bit OPT_LOWPOWER = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_data,
   input  logic        i_last,
   output logic        o_reg_valid,
   input  logic        i_reg_ready,
   output logic [31:0] o_reg_data,
   output logic        o_reg_last,
   output logic        o_data_valid,
   input  logic        i_data_ready,
   output logic [31:0] o_data_data,
   output logic        o_data_last,
   output logic        o_err_empty,
   output logic        o_err_long
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_REG, S_DROP} state_t;

   localparam logic [LGMAXDATA-1:0] COUNT_MAX = '1;

   state_t               state, state_nxt;
   logic [LGMAXDATA-1:0] count;
   logic                 regslot_free, dataslot_free;
   logic                 is_data, accept, count_term;
   logic                 reg_load, data_load, count_clr;
   logic                 empty_set, long_set;

   assign regslot_free  = !o_reg_valid || i_reg_ready;
   assign dataslot_free = !o_data_valid || i_data_ready;
   assign is_data       = (i_data[7:0] == 8'h46);
   assign count_term    = (count == COUNT_MAX);
   assign accept        = i_valid && o_ready;

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept && !i_last) state_nxt = is_data ? S_DATA : S_REG;
         S_REG:  if (accept && i_last)  state_nxt = S_IDLE;
         S_DATA: begin
            if (accept) begin
               if (i_last)          state_nxt = S_IDLE;
               else if (count_term) state_nxt = S_DROP;
            end
         end
         S_DROP: if (accept && i_last)  state_nxt = S_IDLE;
         default:                       state_nxt = S_IDLE;
      endcase
   end

   // Handshake and stage-load controls; the header ready in IDLE depends on the type byte
   always_comb begin
      o_ready   = 1'b0;
      reg_load  = 1'b0;
      data_load = 1'b0;
      count_clr = 1'b0;
      empty_set = 1'b0;
      long_set  = 1'b0;
      case (state)
         S_IDLE: begin
            o_ready = is_data ? 1'b1 : regslot_free;
            if (accept) begin
               if (is_data) begin
                  empty_set = i_last;
                  count_clr = !i_last;
               end else begin
                  reg_load = 1'b1;
               end
            end
         end
         S_REG: begin
            o_ready  = regslot_free;
            reg_load = accept;
         end
         S_DATA: begin
            o_ready   = dataslot_free;
            data_load = accept;
            long_set  = accept && count_term && !i_last;
         end
         S_DROP:  o_ready = 1'b1;
         default: o_ready = 1'b0;
      endcase
   end

   // Register-stream output stage
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_reg_valid <= 1'b0;
         o_reg_data  <= '0;
         o_reg_last  <= 1'b0;
      end else if (reg_load) begin
         o_reg_valid <= 1'b1;
         o_reg_data  <= i_data;
         o_reg_last  <= i_last;
      end else if (i_reg_ready) begin
         o_reg_valid <= 1'b0;
         if (OPT_LOWPOWER) begin
            o_reg_data <= '0;
            o_reg_last <= 1'b0;
         end
      end
   end

   // Data-stream output stage; the word at the size limit is marked last
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_data_valid <= 1'b0;
         o_data_data  <= '0;
         o_data_last  <= 1'b0;
      end else if (data_load) begin
         o_data_valid <= 1'b1;
         o_data_data  <= i_data;
         o_data_last  <= i_last || count_term;
      end else if (i_data_ready) begin
         o_data_valid <= 1'b0;
         if (OPT_LOWPOWER) begin
            o_data_data <= '0;
            o_data_last <= 1'b0;
         end
      end
   end

   // Payload word counter; the terminal word always leaves DATA so it never wraps in use
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)     count <= '0;
      else if (count_clr) count <= '0;
      else if (data_load) count <= count + LGMAXDATA'(1);
   end

   // Error pulses; empty arises only in IDLE and long only in DATA, so they cannot overlap
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_err_empty <= 1'b0;
         o_err_long  <= 1'b0;
      end else begin
         o_err_empty <= empty_set;
         o_err_long  <= long_set;
      end
   end

endmodule

// File: tb/tb_satatrn_rxsplit.sv
// Bench for satatrn_rxsplit: directed cases plus random FIS traffic, checked
// by a scoreboard fed from a FIS-level model of the splitter.
module tb_satatrn_rxsplit;

   localparam int LG   = 2;
   localparam int MAXW = 1 << LG;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_valid, o_ready;
   logic [31:0] i_data;
   logic        i_last;
   logic        o_reg_valid, i_reg_ready, o_reg_last;
   logic [31:0] o_reg_data;
   logic        o_data_valid, i_data_ready, o_data_last;
   logic [31:0] o_data_data;
   logic        o_err_empty, o_err_long;

   satatrn_rxsplit #(.LGMAXDATA(LG), .OPT_LOWPOWER(1'b0)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_last(i_last),
      .o_reg_valid(o_reg_valid), .i_reg_ready(i_reg_ready),
      .o_reg_data(o_reg_data), .o_reg_last(o_reg_last),
      .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
      .o_data_data(o_data_data), .o_data_last(o_data_last),
      .o_err_empty(o_err_empty), .o_err_long(o_err_long)
   );

   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;

   logic [32:0] exp_reg[$];
   logic [32:0] exp_data[$];
   bit          exp_err[$];   // 0 = empty, 1 = long

   int  sink_mode = 0;   // 0 always ready, 1 random, 2 toggling data ready
   bit  in_payload = 0;
   bit  gaps = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Sink ready generation
   initial begin
      i_reg_ready  = 1'b0;
      i_data_ready = 1'b0;
      forever begin
         @(posedge i_clk); #1;
         case (sink_mode)
            0: begin i_reg_ready = 1'b1; i_data_ready = 1'b1; end
            1: begin
               i_reg_ready  = ($urandom_range(0, 3) != 0);
               i_data_ready = ($urandom_range(0, 3) != 0);
            end
            default: begin i_reg_ready = 1'b1; i_data_ready = !i_data_ready; end
         endcase
      end
   end

   // Monitor: pop and compare on each output handshake, check hold stability and error pulses
   bit          reg_stall = 0, data_stall = 0;
   logic [32:0] reg_held, data_held;
   always @(negedge i_clk) begin
      if (!i_reset_n) begin
         reg_stall  = 0;
         data_stall = 0;
      end else begin
         if (reg_stall)
            check("reg_hold", {o_reg_valid, o_reg_last, o_reg_data}, {1'b1, reg_held});
         if (data_stall)
            check("data_hold", {o_data_valid, o_data_last, o_data_data}, {1'b1, data_held});
         if (o_reg_valid && i_reg_ready) begin
            if (exp_reg.size() == 0) check("reg_unexpected", {o_reg_last, o_reg_data}, 0);
            else check("reg_word", {o_reg_last, o_reg_data}, exp_reg.pop_front());
         end
         if (o_data_valid && i_data_ready) begin
            if (exp_data.size() == 0) check("data_unexpected", {o_data_last, o_data_data}, 0);
            else check("data_word", {o_data_last, o_data_data}, exp_data.pop_front());
         end
         if (o_err_empty && o_err_long) check("err_overlap", 2'b11, 2'b00);
         else if (o_err_empty || o_err_long) begin
            if (exp_err.size() == 0) check("err_unexpected", {o_err_long, o_err_empty}, 0);
            else check("err_kind", o_err_long, exp_err.pop_front());
         end
         reg_stall  = o_reg_valid && !i_reg_ready;
         reg_held   = {o_reg_last, o_reg_data};
         data_stall = o_data_valid && !i_data_ready;
         data_held  = {o_data_last, o_data_data};
      end
   end

   // FIS-level model of the splitter
   task automatic expect_fis(input logic [31:0] w[$]);
      int n, fw;
      if (w[0][7:0] == 8'h46) begin
         n = w.size() - 1;
         if (n == 0) exp_err.push_back(1'b0);
         fw = (n > MAXW) ? MAXW : n;
         for (int i = 1; i <= fw; i++) exp_data.push_back({(i == fw), w[i]});
         if (n > MAXW) exp_err.push_back(1'b1);
      end else begin
         for (int i = 0; i < w.size(); i++) exp_reg.push_back({(i == w.size() - 1), w[i]});
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic l);
      int  n = 0;
      bit  acc = 0;
      i_valid = 1'b1; i_data = d; i_last = l;
      while (!acc) begin
         @(negedge i_clk);
         acc = o_ready;
         if (in_payload && o_data_valid && !i_data_ready)
            check("ready_while_held", o_ready, 1'b0);
         @(posedge i_clk); #1;
         n++;
         if (!acc && n > 200) begin
            check("accept_timeout", 0, 1);
            acc = 1;
         end
      end
      i_valid = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
         @(posedge i_clk); #1;
      end
   endtask

   task automatic send_fis(input logic [31:0] w[$]);
      bit dat;
      expect_fis(w);
      dat = (w[0][7:0] == 8'h46);
      for (int i = 0; i < w.size(); i++) begin
         in_payload = dat && i >= 1 && i <= MAXW;
         send_word(w[i], i == w.size() - 1);
      end
      in_payload = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_reg.size() + exp_data.size() + exp_err.size()) != 0 && n < 2000) begin
         @(posedge i_clk); #1;
         n++;
      end
      repeat (3) begin @(posedge i_clk); #1; end
      check("drain_left", exp_reg.size() + exp_data.size() + exp_err.size(), 0);
   endtask

   initial begin
      logic [31:0] w[$];
      logic [7:0]  t;
      int          len;
      i_reset_n = 1'b0; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_outputs", {o_reg_valid, o_data_valid, o_reg_last, o_data_last,
                            o_err_empty, o_err_long}, 0);
      check("rst_data", {o_reg_data, o_data_data}, 0);
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      sink_mode = 0;
      @(posedge i_clk); #1;

      // Register FIS, 5 words
      w = {32'h0050_0034, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
      send_fis(w);
      drain();
      // Data FIS, 4-word payload
      w = {32'h0000_0046, 32'h1, 32'h2, 32'h3, 32'h4};
      send_fis(w);
      drain();
      // Backpressure with toggling data ready
      sink_mode = 2;
      w = {32'h0000_0046, 32'hB1, 32'hB2, 32'hB3};
      send_fis(w);
      drain();
      sink_mode = 0;
      // Empty data FIS then a register FIS
      w = {32'h0000_0046};
      send_fis(w);
      w = {32'h0000_0027, 32'hC1};
      send_fis(w);
      drain();
      // Oversize: 6 payload words
      w = {32'h1234_5646, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5, 32'hD6};
      send_fis(w);
      w = {32'h0000_0046, 32'hE1};
      send_fis(w);
      drain();

      // Reset in the middle of a register FIS
      exp_reg.push_back({1'b0, 32'h0050_0034});
      send_word(32'h0050_0034, 1'b0);
      send_word(32'hF2, 1'b0);
      check("midreg_valid", o_reg_valid, 1'b1);
      i_reset_n = 1'b0;
      #1;
      check("midreg_rst_valid", {o_reg_valid, o_data_valid}, 2'b00);
      @(posedge i_clk); #3;
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      w = {32'h0000_0046, 32'h77};
      send_fis(w);
      drain();

      // Random traffic
      sink_mode = 1;
      gaps = 1;
      for (int k = 0; k < 60; k++) begin
         w = {};
         if ($urandom_range(0, 1) == 1) begin
            w.push_back({$urandom_range(0, 32'hFFFF), 8'h00, 8'h46});
            len = $urandom_range(0, 6);
         end else begin
            t = 8'($urandom_range(0, 255));
            if (t == 8'h46) t = 8'h34;
            w.push_back({$urandom_range(0, 32'hFFFF), 8'h00, t});
            len = $urandom_range(0, 5);
         end
         for (int i = 0; i < len; i++) w.push_back($urandom);
         send_fis(w);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
